fp_normalize_seq: RTL and testbench
===================================

// Module: fp_normalize_seq
// PURPOSE
//  Sequential normalize/pack stage that sits directly downstream of the FP32 adder datapath.
//  It takes the adder's raw sign, 9-bit exponent and 25-bit mantissa (bit24 = carry, bit23 = hidden 1).
//  It normalizes the mantissa one bit per cycle and packs an IEEE-754 single result with NZCV flags.
//  The multi-cycle controller starts it and waits for done.
// PARAMETERS
//  EXP_W  8   exponent field width; result exponent field = EXP_W bits
//  MAN_W  23  stored mantissa width; raw mantissa input = MAN_W+2 bits
// PORTS
//  clk      in   1   single clock; all state updates on the rising edge
//  reset    in   1   asynchronous, active-high; clears all state and outputs
//  start    in   1   request; sampled only in IDLE
//  sign_in  in   1   raw result sign
//  exp_in   in   9   raw biased exponent; bit8 set means the exponent already overflowed
//  mant_in  in   25  raw mantissa {carry, hidden, frac[22:0]}
//  busy     out  1   high from the accept edge until done is high
//  done     out  1   one-cycle pulse; result and flags valid in that cycle and held afterwards
//  result   out  32  packed {sign, exp[7:0], frac[22:0]}
//  flags    out  4   {N, Z, C, V}
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, result and flags are all 0. Reset mid-operation aborts the operation; no done is produced.
//  Internal registers: sign, 10-bit exponent (no wrap), 25-bit mantissa, carry flag.
//  IDLE: if start=1, latch sign_in/exp_in/mant_in and clear C, then go to NORM.
//    start while not IDLE is ignored; there is no queueing.
//  NORM (evaluated in priority order, one action per cycle):
//    1. mant==0  -> zero case -> PACK
//    2. mant[24] -> mant>>=1, exp+=1, C=1 -> PACK (a single right shift always suffices)
//    3. mant[23] -> PACK
//    4. exp<=1   -> underflow: flush to zero -> PACK
//    5. else     -> mant<<=1, exp-=1, stay in NORM
//  PACK (one cycle): register result and flags, assert done, clear busy, then go to IDLE.
//    Zero/flush: result=32'h00000000 (+0), Z=1, N=0.
//    exp>=255 (includes input bit8): result={sign,8'hFF,23'b0} (infinity), V=1.
//    Otherwise: result={sign, exp[7:0], mant[22:0]}. Truncation only; no rounding.
//    N=result[31]; C=1 iff a carry right-shift occurred; V and Z are mutually exclusive.
//  Latency: start edge -> done high after 2+k cycles, where k = number of left shifts (k<=23).
//  done is high for exactly one cycle. start may be reasserted in the cycle after done (back-to-back).
//  busy and done are never high together. result and flags stay stable until the next PACK or reset.
// TESTING
//  1. sign=0, exp=9'h07F, mant=25'h1000000 (1+1 carry) -> result 32'h40000000, flags 4'b0010, done 2 cycles after start.
//  2. sign=1, exp=9'h080, mant=25'h0C00000 -> result 32'hC0400000, flags 4'b1000, done after 2 cycles.
//  3. sign=0, exp=9'h07F, mant=25'h0200000 -> 2 left shifts -> result 32'h3E800000, flags 4'b0000, done after 4 cycles.
//  4. mant=25'h0 with any exp -> result 32'h00000000, flags 4'b0100.
//     exp=9'h002, mant=25'h0000001 -> flushed to 32'h00000000, flags 4'b0100.
//  5. exp=9'h0FE, mant=25'h1000000 -> result 32'h7F800000, flags 4'b0011.
//     exp=9'h100 -> V=1, result 32'h7F800000.
//  6. Assert reset during a shift sequence (case 3) -> busy=0, done=0, result=0 immediately.
//     start asserted mid-operation is ignored; back-to-back starts on the cycle after done are both accepted and produce 2 done pulses.

Source files
------------

// File: rtl/fp_normalize_seq_if.sv
// Handshake and data bundle between the FP normalize/pack stage and its controller.
// The controller drives the raw operands and start; the stage returns the packed result and flags.
interface fp_normalize_seq_if #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
);
   logic                   start;
   logic                   sign_in;
   logic [EXP_W:0]         exp_in;
   logic [MAN_W+1:0]       mant_in;
   logic                   busy;
   logic                   done;
   logic [EXP_W+MAN_W:0]   result;
   logic [3:0]             flags;

   modport master (
      output start, sign_in, exp_in, mant_in,
      input  busy, done, result, flags
   );

   modport slave (
      input  start, sign_in, exp_in, mant_in,
      output busy, done, result, flags
   );
endinterface

// File: rtl/fp_normalize_seq.sv
// Sequential normalize/pack stage after the FP32 adder: shifts the raw mantissa one bit per
// cycle until the hidden bit is in place, then packs an IEEE-754 single with NZCV flags.
module fp_normalize_seq #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input logic              clk,
   input logic              reset,
   fp_normalize_seq_if.slave bus
);

   localparam int unsigned XW = EXP_W + 2;
   localparam int unsigned MW = MAN_W + 2;
   localparam logic [XW-1:0] ExpOne = XW'(1);
   localparam logic [XW-1:0] ExpMax = {2'b00, {EXP_W{1'b1}}};

   typedef enum logic [1:0] {StIdle, StNorm, StPack} state_e;

   state_e           state_q;
   logic             sign_q;
   logic [XW-1:0]    exp_q;
   logic [MW-1:0]    mant_q;
   logic             carry_q;

   logic                   pack_zero;
   logic                   pack_inf;
   logic [EXP_W+MAN_W:0]   pack_result;
   logic [3:0]             pack_flags;

   // Zero takes precedence over overflow so a zero mantissa never packs as infinity.
   always_comb begin
      pack_zero   = (mant_q == '0);
      pack_inf    = (exp_q >= ExpMax);
      pack_result = {sign_q, exp_q[EXP_W-1:0], mant_q[MAN_W-1:0]};
      if (pack_zero) begin
         pack_result = '0;
      end else if (pack_inf) begin
         pack_result = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
      pack_flags = {pack_result[EXP_W+MAN_W], pack_zero, carry_q, ~pack_zero & pack_inf};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         sign_q     <= 1'b0;
         exp_q      <= '0;
         mant_q     <= '0;
         carry_q    <= 1'b0;
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
         bus.result <= '0;
         bus.flags  <= '0;
      end else begin
         bus.done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  sign_q   <= bus.sign_in;
                  exp_q    <= {1'b0, bus.exp_in};
                  mant_q   <= bus.mant_in;
                  carry_q  <= 1'b0;
                  bus.busy <= 1'b1;
                  state_q  <= StNorm;
               end
            end
            StNorm: begin
               if (mant_q == '0) begin
                  state_q <= StPack;
               end else if (mant_q[MW-1]) begin
                  mant_q  <= mant_q >> 1;
                  exp_q   <= exp_q + ExpOne;
                  carry_q <= 1'b1;
                  state_q <= StPack;
               end else if (mant_q[MAN_W]) begin
                  state_q <= StPack;
               end else if (exp_q <= ExpOne) begin
                  // Underflow: clearing the mantissa lets PACK take the zero path.
                  mant_q  <= '0;
                  state_q <= StPack;
               end else begin
                  mant_q  <= mant_q << 1;
                  exp_q   <= exp_q - ExpOne;
               end
            end
            StPack: begin
               bus.result <= pack_result;
               bus.flags  <= pack_flags;
               bus.done   <= 1'b1;
               bus.busy   <= 1'b0;
               state_q    <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_normalize_seq.sv
// Scoreboard bench for fp_normalize_seq: stimulus pushes hand-computed results, a monitor pops
// and compares result, flags and start-to-done latency whenever done is seen.
module tb_fp_normalize_seq;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   fails = 0;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  flg;
      int          acc;
      int          lat;
   } exp_t;

   exp_t sb[$];

   fp_normalize_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();

   fp_normalize_seq #(.EXP_W(8), .MAN_W(23)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: pops one expectation per done pulse.
   always @(negedge clk) begin
      if (!reset && bus.done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'(bus.done), 32'h0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", bus.result, e.res);
            check("flags", 32'(bus.flags), 32'(e.flg));
            check("latency", 32'(cyc - e.acc), 32'(e.lat));
            check("busy_with_done", 32'(bus.busy), 32'h0);
         end
      end
   end

   // Called at a negedge; the following posedge accepts.
   task automatic issue(input logic s, input logic [8:0] e, input logic [24:0] m,
                        input logic [31:0] r, input logic [3:0] f, input int lat, input bit push);
      exp_t x;
      bus.sign_in = s;
      bus.exp_in  = e;
      bus.mant_in = m;
      bus.start   = 1'b1;
      if (push) begin
         x.res = r; x.flg = f; x.acc = cyc + 1; x.lat = lat;
         sb.push_back(x);
      end
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         check("drain_timeout", 32'(sb.size()), 32'h0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      int n;
      reset       = 1'b1;
      bus.start   = 1'b0;
      bus.sign_in = 1'b0;
      bus.exp_in  = '0;
      bus.mant_in = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_done", 32'(bus.done), 32'h0);
      check("rst_result", bus.result, 32'h0);
      check("rst_flags", 32'(bus.flags), 32'h0);
      reset = 1'b0;
      @(negedge clk);

      issue(1'b0, 9'h07F, 25'h1000000, 32'h40000000, 4'b0010, 2, 1'b1); drain();
      issue(1'b1, 9'h080, 25'h0C00000, 32'hC0400000, 4'b1000, 2, 1'b1); drain();
      issue(1'b0, 9'h07F, 25'h0200000, 32'h3E800000, 4'b0000, 4, 1'b1); drain();
      issue(1'b1, 9'h090, 25'h0300001, 32'hC7400004, 4'b1000, 4, 1'b1); drain();
      issue(1'b1, 9'h155, 25'h0000000, 32'h00000000, 4'b0100, 2, 1'b1); drain();
      issue(1'b0, 9'h002, 25'h0000001, 32'h00000000, 4'b0100, 3, 1'b1); drain();
      issue(1'b0, 9'h0FE, 25'h1000000, 32'h7F800000, 4'b0011, 2, 1'b1); drain();
      issue(1'b0, 9'h100, 25'h0800000, 32'h7F800000, 4'b0001, 2, 1'b1); drain();
      issue(1'b1, 9'h1FF, 25'h1000000, 32'hFF800000, 4'b1011, 2, 1'b1); drain();

      // start while busy must not disturb the running operation
      issue(1'b0, 9'h07F, 25'h0200000, 32'h3E800000, 4'b0000, 4, 1'b1);
      issue(1'b1, 9'h0FE, 25'h1000000, 32'h0, 4'b0, 0, 1'b0);
      drain();

      // back-to-back: second start driven during the done cycle of the first
      issue(1'b0, 9'h07F, 25'h1000000, 32'h40000000, 4'b0010, 2, 1'b1);
      n = 0;
      while (!bus.done && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("b2b_first_done", 32'(bus.done), 32'h1);
      issue(1'b1, 9'h080, 25'h0C00000, 32'hC0400000, 4'b1000, 2, 1'b1);
      drain();

      // reset in the middle of a shift sequence aborts it
      issue(1'b0, 9'h07F, 25'h0200000, 32'h0, 4'b0, 0, 1'b0);
      @(negedge clk);
      check("pre_rst_busy", 32'(bus.busy), 32'h1);
      reset = 1'b1;
      #1;
      check("abort_busy", 32'(bus.busy), 32'h0);
      check("abort_done", 32'(bus.done), 32'h0);
      check("abort_result", bus.result, 32'h0);
      check("abort_flags", 32'(bus.flags), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check("post_abort_busy", 32'(bus.busy), 32'h0);
      check("post_abort_result", bus.result, 32'h0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
